ift_response_checker: RTL and testbench

IFT_RESPONSE_CHECKER -- requirements
Module: ift_response_checker

---
 rtl/ift_response_checker.sv | 174 +++++++++++++++++
 tb/tb_ift_response_checker.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ift_response_checker.sv
// ift_response_checker
//
// Purpose:
//   Checks the response of an information-flow-tracking DUT against a small
//   table of expected output vectors. The table is loaded while no run is
//   active. A start pulse begins a run. Each sampled DUT output is compared
//   with the next table entry, in order. The block counts mismatches,
//   remembers the index of the first one, and ORs together every sampled
//   taint vector. After DEPTH samples the run ends and the results are held.
//
// Configuration:
//   IFT_CHECK_VALUE_EN - when defined, a sample also mismatches if dut_val
//                        differs from the stored expected value. When it is
//                        undefined, only the taint vector is compared and no
//                        expected values are stored.
//
// Handshake:
//   'sample' is a valid-only qualifier. There is no ready. Every cycle in RUN
//   with sample=1 consumes exactly one table entry. Samples outside RUN are
//   dropped.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset (table kept)
//   exp_wr_en/addr/   expected-table write port (dropped while busy)
//   exp_wr_val/taint
//   start             begins a run from IDLE or DONE (ignored in RUN)
//   sample, dut_val,  DUT output under check
//   dut_taint
//   busy, done, pass  run status
//   mismatch_cnt      mismatching samples in current/last run
//   first_fail_valid  at least one mismatch recorded
//   first_fail_idx    index of the first mismatching sample
//   taint_union       OR of all sampled taint vectors in the run
//   o_dbg_state       current FSM state (debug)

module ift_response_checker #(
    parameter int TAINT_W = 32,
    parameter int DEPTH   = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               exp_wr_en,
    input  logic [IDX_W-1:0]   exp_wr_addr,
    input  logic               exp_wr_val,
    input  logic [TAINT_W-1:0] exp_wr_taint,
    input  logic               start,
    input  logic               sample,
    input  logic               dut_val,
    input  logic [TAINT_W-1:0] dut_taint,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [IDX_W:0]     mismatch_cnt,
    output logic               first_fail_valid,
    output logic [IDX_W-1:0]   first_fail_idx,
    output logic [TAINT_W-1:0] taint_union,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W:0]     r_mismatch_cnt;
    logic               r_ff_valid;
    logic [IDX_W-1:0]   r_ff_idx;
    logic [TAINT_W-1:0] r_taint_union;

    // Expected table. It has no reset so that it survives a reset.
    logic [TAINT_W-1:0] r_exp_taint [DEPTH];

    logic w_wr_ok;
    logic w_start_run;
    logic w_take;
    logic w_mismatch;

    assign w_wr_ok     = exp_wr_en && (r_state != S_RUN);
    assign w_start_run = start && (r_state != S_RUN);
    assign w_take      = sample && (r_state == S_RUN);

`ifdef IFT_CHECK_VALUE_EN
    logic r_exp_val [DEPTH];

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_exp_val[exp_wr_addr] <= exp_wr_val;
        end
    end

    assign w_mismatch = (dut_taint != r_exp_taint[r_idx]) ||
                        (dut_val != r_exp_val[r_idx]);
`else
    // Value inputs are not used when only taint is compared.
    logic w_unused_val;
    assign w_unused_val = exp_wr_val ^ dut_val;

    assign w_mismatch = (dut_taint != r_exp_taint[r_idx]);
`endif

    // A write that coincides with start lands on this same edge. The first
    // sample can only be taken on a later edge, so the run sees the new entry.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_exp_taint[exp_wr_addr] <= exp_wr_taint;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (sample && (r_idx == LAST_IDX)) w_next_state = S_DONE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx          <= '0;
            r_mismatch_cnt <= '0;
            r_ff_valid     <= 1'b0;
            r_ff_idx       <= '0;
            r_taint_union  <= '0;
        end else if (w_start_run) begin
            r_idx          <= '0;
            r_mismatch_cnt <= '0;
            r_ff_valid     <= 1'b0;
            r_ff_idx       <= '0;
            r_taint_union  <= '0;
        end else if (w_take) begin
            // The index wraps to 0 naturally after DEPTH-1. The count cannot
            // exceed DEPTH, which fits in IDX_W+1 bits.
            r_idx         <= r_idx + 1'b1;
            r_taint_union <= r_taint_union | dut_taint;
            if (w_mismatch) begin
                r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
                if (!r_ff_valid) begin
                    r_ff_valid <= 1'b1;
                    r_ff_idx   <= r_idx;
                end
            end
        end
    end

    assign busy             = (r_state == S_RUN);
    assign done             = (r_state == S_DONE);
    assign pass             = done && (r_mismatch_cnt == '0);
    assign mismatch_cnt     = r_mismatch_cnt;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_idx   = r_ff_idx;
    assign taint_union      = r_taint_union;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_ift_response_checker.sv
module tb_ift_response_checker;

    localparam int TW    = 32;
    localparam int DEPTH = 8;
    localparam int IW    = 3;

`ifdef IFT_CHECK_VALUE_EN
    localparam bit CHECK_VAL = 1'b1;
`else
    localparam bit CHECK_VAL = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          exp_wr_en = 1'b0;
    logic [IW-1:0] exp_wr_addr = '0;
    logic          exp_wr_val = 1'b0;
    logic [TW-1:0] exp_wr_taint = '0;
    logic          start = 1'b0;
    logic          sample = 1'b0;
    logic          dut_val = 1'b0;
    logic [TW-1:0] dut_taint = '0;
    logic          busy, done, pass;
    logic [IW:0]   mismatch_cnt;
    logic          first_fail_valid;
    logic [IW-1:0] first_fail_idx;
    logic [TW-1:0] taint_union;
    logic [1:0]    dbg_state;

    ift_response_checker #(.TAINT_W(TW), .DEPTH(DEPTH), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr),
        .exp_wr_val(exp_wr_val), .exp_wr_taint(exp_wr_taint),
        .start(start), .sample(sample), .dut_val(dut_val), .dut_taint(dut_taint),
        .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
        .taint_union(taint_union), .o_dbg_state(dbg_state)
    );

    // ---------------- reference model ----------------
    // The run is a list of consumed samples. Every expected output is
    // recomputed from that list and the expected table.
    typedef struct {
        logic          val;
        logic [TW-1:0] taint;
    } samp_t;

    logic [TW-1:0] m_taint [DEPTH];
    logic          m_val   [DEPTH];
    bit            m_running = 1'b0;
    bit            m_done = 1'b0;
    samp_t         m_q[$];

    int n_cmp = 0;
    int n_mis = 0;

    function automatic bit is_mismatch(int i, samp_t s);
        return (s.taint != m_taint[i]) || (CHECK_VAL && (s.val != m_val[i]));
    endfunction

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int            cnt = 0;
        bit            ffv = 1'b0;
        int            ffi = 0;
        logic [TW-1:0] uni = '0;
        for (int i = 0; i < m_q.size(); i++) begin
            uni |= m_q[i].taint;
            if (is_mismatch(i, m_q[i])) begin
                cnt++;
                if (!ffv) begin
                    ffv = 1'b1;
                    ffi = i;
                end
            end
        end
        chk({tag, ".busy"}, TW'(busy), TW'(m_running));
        chk({tag, ".done"}, TW'(done), TW'(m_done));
        chk({tag, ".pass"}, TW'(pass), TW'(m_done && cnt == 0));
        chk({tag, ".cnt"}, TW'(mismatch_cnt), TW'(cnt));
        chk({tag, ".ffv"}, TW'(first_fail_valid), TW'(ffv));
        chk({tag, ".ffi"}, TW'(first_fail_idx), TW'(ffi));
        chk({tag, ".union"}, taint_union, uni);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input logic v, input logic [TW-1:0] t);
        exp_wr_en = 1'b1; exp_wr_addr = IW'(a); exp_wr_val = v; exp_wr_taint = t;
        tick();
        exp_wr_en = 1'b0;
        if (!m_running) begin
            m_taint[a] = t;
            m_val[a] = v;
        end
    endtask

    task automatic model_start();
        if (!m_running) begin
            m_running = 1'b1;
            m_done = 1'b0;
            m_q.delete();
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_start();
    endtask

    task automatic do_start_write(input int a, input logic v, input logic [TW-1:0] t);
        start = 1'b1;
        exp_wr_en = 1'b1; exp_wr_addr = IW'(a); exp_wr_val = v; exp_wr_taint = t;
        tick();
        start = 1'b0;
        exp_wr_en = 1'b0;
        if (!m_running) begin
            m_taint[a] = t;
            m_val[a] = v;
        end
        model_start();
    endtask

    task automatic do_sample(input logic v, input logic [TW-1:0] t);
        samp_t s;
        sample = 1'b1; dut_val = v; dut_taint = t;
        tick();
        sample = 1'b0;
        if (m_running) begin
            s.val = v;
            s.taint = t;
            m_q.push_back(s);
            if (m_q.size() == DEPTH) begin
                m_running = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_running = 1'b0;
        m_done = 1'b0;
        m_q.delete();
    endtask

    // Sample matching the loaded entry i (taint=i, val=i[0])
    task automatic sample_idx(input int i);
        logic [TW-1:0] t;
        t = TW'(i);
        do_sample(t[0], t);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int guard;
        logic [TW-1:0] t;
        logic v;
        int k;

        #1 rst_n = 1'b0;
        #2;
        check_all("reset0");
        tick();
        rst_n = 1'b1;
        tick();
        check_all("idle0");

        // Load taint=i, val=i[0]
        for (int i = 0; i < DEPTH; i++) begin
            t = TW'(i);
            do_write(i, t[0], t);
        end
        check_all("loaded");

        // All samples match
        do_start();
        check_all("s036.start");
        for (int i = 0; i < DEPTH; i++) begin
            sample_idx(i);
            check_all("s036.step");
        end
        chk("s036.done", TW'(done), 1);
        chk("s036.pass", TW'(pass), 1);
        chk("s036.union", taint_union, 32'h7);

        // Sample in DONE is ignored; outputs hold
        do_sample(1'b1, 32'hDEAD);
        tick();
        check_all("s041.done_sample");

        // Mismatches at 2 and 5
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 2) do_sample(1'b0, 32'hFF);
            else if (i == 5) do_sample(1'b1, 32'h0);
            else sample_idx(i);
            check_all("s037.step");
        end
        chk("s037.cnt", TW'(mismatch_cnt), 2);
        chk("s037.ffi", TW'(first_fail_idx), 2);
        chk("s037.pass", TW'(pass), 0);

        // Value-only mismatch at entry 3
        do_write(3, 1'b1, 32'h3);
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 3) do_sample(1'b0, 32'h3);
            else sample_idx(i);
        end
        check_all("s038.end");
        chk("s038.cnt", TW'(mismatch_cnt), CHECK_VAL ? 1 : 0);

        // Write during RUN is dropped; both runs use old entry 0
        do_start();
        do_write(0, 1'b1, 32'hABC);
        for (int i = 0; i < DEPTH; i++) sample_idx(i);
        check_all("s039.run1");
        chk("s039.cnt1", TW'(mismatch_cnt), 0);
        do_start();
        for (int i = 0; i < DEPTH; i++) sample_idx(i);
        check_all("s039.run2");
        chk("s039.cnt2", TW'(mismatch_cnt), 0);

        // Start pulsed during RUN is ignored
        do_start();
        for (int i = 0; i < 3; i++) sample_idx(i);
        do_start();
        check_all("s041.start_in_run");
        chk("s041.cnt_mid", TW'(mismatch_cnt), 0);
        for (int i = 3; i < DEPTH; i++) sample_idx(i);
        check_all("s041.end");

        // Start coinciding with a write uses the new entry
        do_start_write(4, 1'b0, 32'h44);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 4) do_sample(1'b0, 32'h44);
            else sample_idx(i);
        end
        check_all("s029.end");
        chk("s029.pass", TW'(pass), 1);
        do_write(4, 1'b0, 32'h4);

        // Asynchronous reset mid-run
        do_start();
        for (int i = 0; i < 4; i++) sample_idx(i);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("s040.async");
        chk("s040.union0", taint_union, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check_all("s040.idle");
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            sample_idx(i);
            check_all("s040.fresh");
        end
        chk("s040.done", TW'(done), 1);

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            k = $urandom_range(0, 3);
            for (int w = 0; w < k; w++)
                do_write($urandom_range(0, DEPTH - 1), 1'($urandom), TW'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1)
                do_start_write($urandom_range(0, DEPTH - 1), 1'($urandom), TW'($urandom_range(0, 15)));
            else
                do_start();
            check_all("rnd.start");
            guard = 0;
            while (m_running && guard < 200) begin
                guard++;
                case ($urandom_range(0, 7))
                    0: tick();
                    1: do_write($urandom_range(0, DEPTH - 1), 1'($urandom), TW'($urandom));
                    2: do_start();
                    default: begin
                        k = m_q.size();
                        t = m_taint[k];
                        v = m_val[k];
                        if ($urandom_range(0, 3) == 0) t = TW'($urandom_range(0, 15));
                        if ($urandom_range(0, 3) == 0) v = ~v;
                        do_sample(v, t);
                    end
                endcase
                check_all("rnd.step");
            end
            chk("rnd.finished", TW'(m_running), 0);
            do_sample(1'($urandom), TW'($urandom));
            check_all("rnd.after_done");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
